execute_stage: RTL
==================

Name: execute_stage

Overview:
- Execute stage of the vector pipeline. It sits directly upstream of the memory stage and drives that stage's input bundle.
- Computes scalar, vector and address results over 144-bit operands, organised as 6 lanes x 24 bits.
- Lane i occupies bits [24i+23:24i].
- Single-cycle ops complete in one cycle. VMUL is iterative (one lane per cycle); the block stalls the front of the pipe while VMUL runs.
- Results are held in an output pipeline register, EX/MEM.

Parameters:
- LANES, 6, number of vector lanes.
- LANE_W, 24, lane width in bits; VEC_W = LANES*LANE_W = 144.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  pipeline advance; 0 freezes FSM and EX/MEM register
- flush  in  1  synchronous; loads a bubble into EX/MEM
- opType  in  2  00 scalar, 01 vector, 10 memory, 11 pass-through
- opCode  in  4  operation select
- srcA  in  144  vector operand A
- srcB  in  144  vector operand B
- scalarB  in  24  scalar operand / offset / shift amount
- storeData  in  144  data for vector store
- memWrite, memToReg, regWrite, regWriteV, modeSel  in  1 each  control bits, carried through
- Rc  in  4  destination register
- stall  out  1  combinational; upstream holds all inputs while 1
- opTypeM  out  2; opCodeM  out  4
- address1  out  144  ALU result / vector address
- address2  out  24  registered scalarB
- writeDataM  out  144; RcM  out  4
- memWriteM, memToRegM, regWriteM, regWriteVM, modeSelM  out  1 each

Behaviour:
- Reset (rst=0, async): all outputs 0, FSM=IDLE, lane counter=0, accumulator=0.
- Lane functions f(a,b), all mod 2^24:
  - 0 ADD a+b; 1 SUB a-b; 2 AND; 3 OR; 4 XOR.
  - 5 SHL a<<b[4:0]; 6 SHR logical a>>b[4:0]. Shift >=24 gives 0.
  - 7 MUL: low 24 bits of a*b.
  - 8-15: result = a.
- opType 00: lane0 = f(srcA lane0, scalarB); other lanes 0. Scalar MUL is single-cycle.
- opType 01: lane i = f(srcA lane i, srcB lane i). For SHL/SHR, b = scalarB for every lane.
- opType 10: address1 = {120'b0, srcA[23:0]+scalarB} mod 2^24; opCode ignored.
- opType 11: address1 = srcA.
- Single-cycle ops: stall=0. On the edge with en=1, EX/MEM loads the result plus all control fields, Rc and writeData. Latency is 1 cycle.
- FSM IDLE/BUSY/DONE, used only for vector MUL (opType=01, opCode=7):
  - IDLE: VMUL at the inputs drives stall=1 combinationally. On the en=1 edge: latch srcA, srcB and controls; go to BUSY with cnt=0. EX/MEM is not loaded.
  - BUSY: stall=1. Each en=1 edge writes lane cnt of the product into the accumulator and increments cnt. The edge with cnt=5 goes to DONE.
  - DONE: stall=0. On the en=1 edge, EX/MEM loads the accumulator and latched controls; go to IDLE.
  - Timing: stall is high for 7 cycles. The result is visible 8 edges after VMUL first appears. The instruction is consumed exactly once.
- en=0: FSM, cnt, accumulator and EX/MEM hold. stall keeps its state-derived value.
- flush=1 with en=1:
  - EX/MEM loads a bubble: all control bits 0, data 0.
  - An in-progress VMUL is aborted: FSM to IDLE, cnt=0.
  - flush has priority over a result load.
- Back-to-back VMUL: in DONE, the next VMUL at the inputs is not started until the FSM returns to IDLE. stall rises again in the following cycle.
- rst asserted mid-VMUL: abort immediately; stall=0 after reset release.

Test Plan:
- Vector ADD: srcA all lanes 24'hFFFFFF, srcB all lanes 24'h000002, en=1 -> after 1 edge every lane of address1 = 24'h000001 (wrap); regWriteVM mirrors input.
- Memory op: opType=10, srcA[23:0]=24'h000100, scalarB=24'h000020 -> address1 = 144'h120 and address2 = 24'h000020 one edge later; memWriteM=1 when input memWrite=1.
- VMUL: lanes i of A = i+1, B = 24'h000003 -> stall high for exactly 7 cycles; address1 lanes = 3,6,9,12,15,18 appear after the 8th edge; EX/MEM unchanged before that.
- VMUL with en=0 for 3 cycles mid-BUSY -> stall is extended by 3 cycles; same final result.
- flush during BUSY -> next edge: all control outputs 0, stall=0, FSM=IDLE; a following ADD completes normally.
- Async reset during BUSY, asserted between edges -> outputs 0 immediately, without waiting for a clock edge; after release the pipeline accepts a new ADD with 1-cycle latency.

Source files
------------

// File: rtl/execute_stage.sv
// Execute stage of the vector pipeline: scalar/vector/address ALU over LANES x LANE_W
// operands, an iterative lane-serial vector multiply, and the EX/MEM output register.
module execute_stage #(
    parameter int LANES  = 6,
    parameter int LANE_W = 24
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      flush,
    input  logic [1:0]                opType,
    input  logic [3:0]                opCode,
    input  logic [LANES*LANE_W-1:0]   srcA,
    input  logic [LANES*LANE_W-1:0]   srcB,
    input  logic [LANE_W-1:0]         scalarB,
    input  logic [LANES*LANE_W-1:0]   storeData,
    input  logic                      memWrite,
    input  logic                      memToReg,
    input  logic                      regWrite,
    input  logic                      regWriteV,
    input  logic                      modeSel,
    input  logic [3:0]                Rc,
    output logic                      stall,
    output logic [1:0]                opTypeM,
    output logic [3:0]                opCodeM,
    output logic [LANES*LANE_W-1:0]   address1,
    output logic [LANE_W-1:0]         address2,
    output logic [LANES*LANE_W-1:0]   writeDataM,
    output logic [3:0]                RcM,
    output logic                      memWriteM,
    output logic                      memToRegM,
    output logic                      regWriteM,
    output logic                      regWriteVM,
    output logic                      modeSelM
);

    localparam int VEC_W = LANES * LANE_W;
    localparam int CNT_W = $clog2(LANES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LANES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    function automatic logic [LANE_W-1:0] mul_lo(input logic [LANE_W-1:0] a,
                                                 input logic [LANE_W-1:0] b);
        return a * b;
    endfunction

    // mul_en is tied low on the parallel vector lanes so no per-lane multiplier is built
    function automatic logic [LANE_W-1:0] lane_op(input logic [3:0]        op,
                                                  input logic [LANE_W-1:0] a,
                                                  input logic [LANE_W-1:0] b,
                                                  input logic              mul_en);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return (int'(sh) >= LANE_W) ? '0 : a << sh;
            4'd6:    return (int'(sh) >= LANE_W) ? '0 : a >> sh;
            4'd7:    return mul_en ? mul_lo(a, b) : '0;
            default: return a;
        endcase
    endfunction

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [VEC_W-1:0]   acc;
    logic [VEC_W-1:0]   result;
    logic               vmul_in, shift_op, start, load_new, load_acc;

    logic [VEC_W-1:0]   a_lat, b_lat, store_lat;
    logic [LANE_W-1:0]  scalar_lat;
    logic [1:0]         type_lat;
    logic [3:0]         code_lat, rc_lat;
    logic [4:0]         ctl_lat;
    logic [LANE_W-1:0]  busy_lane;

    assign vmul_in  = (opType == 2'b01) && (opCode == 4'd7);
    assign shift_op = (opCode == 4'd5) || (opCode == 4'd6);
    assign start    = en && !flush && (state == IDLE) && vmul_in;
    assign load_new = en && !flush && (state == IDLE) && !vmul_in;
    assign load_acc = en && !flush && (state == DONE);
    assign busy_lane = mul_lo(a_lat[int'(cnt)*LANE_W +: LANE_W], b_lat[int'(cnt)*LANE_W +: LANE_W]);

    always_comb begin
        result = '0;
        case (opType)
            2'b00: result[LANE_W-1:0] = lane_op(opCode, srcA[LANE_W-1:0], scalarB, 1'b1);
            2'b01: begin
                for (int i = 0; i < LANES; i++) begin
                    result[i*LANE_W +: LANE_W] = lane_op(opCode, srcA[i*LANE_W +: LANE_W],
                        shift_op ? scalarB : srcB[i*LANE_W +: LANE_W], 1'b0);
                end
            end
            2'b10:   result[LANE_W-1:0] = srcA[LANE_W-1:0] + scalarB;
            default: result = srcA;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else if (en) begin
            state <= state_nxt;
        end
    end

    // stall is masked during reset so every output reads 0 while rst is low
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                stall = vmul_in;
                if (vmul_in) state_nxt = BUSY;
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
        stall = stall && rst;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            acc <= '0;
        end else if (en) begin
            if (flush || state != BUSY) begin
                cnt <= '0;
            end else begin
                acc[int'(cnt)*LANE_W +: LANE_W] <= busy_lane;
                cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            type_lat <= '0;
            code_lat <= '0;
            rc_lat   <= '0;
            ctl_lat  <= '0;
        end else if (start) begin
            type_lat <= opType;
            code_lat <= opCode;
            rc_lat   <= Rc;
            ctl_lat  <= {memWrite, memToReg, regWrite, regWriteV, modeSel};
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            a_lat      <= srcA;
            b_lat      <= srcB;
            store_lat  <= storeData;
            scalar_lat <= scalarB;
        end
    end

    // EX/MEM register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            opTypeM    <= '0;
            opCodeM    <= '0;
            address1   <= '0;
            address2   <= '0;
            writeDataM <= '0;
            RcM        <= '0;
            {memWriteM, memToRegM, regWriteM, regWriteVM, modeSelM} <= '0;
        end else if (en) begin
            if (flush) begin
                opTypeM    <= '0;
                opCodeM    <= '0;
                address1   <= '0;
                address2   <= '0;
                writeDataM <= '0;
                RcM        <= '0;
                {memWriteM, memToRegM, regWriteM, regWriteVM, modeSelM} <= '0;
            end else if (load_new) begin
                opTypeM    <= opType;
                opCodeM    <= opCode;
                address1   <= result;
                address2   <= scalarB;
                writeDataM <= storeData;
                RcM        <= Rc;
                {memWriteM, memToRegM, regWriteM, regWriteVM, modeSelM} <=
                    {memWrite, memToReg, regWrite, regWriteV, modeSel};
            end else if (load_acc) begin
                opTypeM    <= type_lat;
                opCodeM    <= code_lat;
                address1   <= acc;
                address2   <= scalar_lat;
                writeDataM <= store_lat;
                RcM        <= rc_lat;
                {memWriteM, memToRegM, regWriteM, regWriteVM, modeSelM} <= ctl_lat;
            end
        end
    end

endmodule
